// File: rtl/fpu_square_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : fpu_square_seq_if
// Brief   : Start/done handshake and result bundle for the FP32 squarer.
// Revision: 1.0 - initial release
// ============================================================================
interface fpu_square_seq_if;
    logic        start;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [31:0] z;
    logic [7:0]  status;

    modport master (output start, a, input busy, done, z, status);
    modport slave  (input start, a, output busy, done, z, status);
endinterface
`default_nettype wire

// File: rtl/fpu_square_seq.sv
`default_nettype none
// ============================================================================
// Module  : fpu_square_seq
// Brief   : Multi-cycle FP32 squarer, shift-add multiply, RNE rounding.
// Revision: 1.0 - initial release
// ============================================================================
module fpu_square_seq (
    input  wire logic        clk,
    input  wire logic        rst,
    fpu_square_seq_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_MUL    = 3'd2;
    localparam logic [2:0] S_NORM   = 3'd3;
    localparam logic [2:0] S_ROUND  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [31:0] c_QNAN = 32'h7FC00000;
    localparam logic [31:0] c_INF  = 32'h7F800000;

    logic [2:0]        r_state;
    logic [30:0]       r_a;
    logic [47:0]       r_mcand;
    logic [23:0]       r_mplier;
    logic [47:0]       r_acc;
    logic [4:0]        r_cnt;
    logic signed [9:0] r_exp;
    logic [23:0]       r_mant;
    logic              r_guard;
    logic              r_sticky;
    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_z;
    logic [7:0]        r_status;

    logic [7:0]        w_exp_in;
    logic [22:0]       w_frac_in;
    logic              w_round_up;
    logic [24:0]       w_mant_sum;
    logic signed [9:0] w_exp_rnd;
    logic [22:0]       w_mant_fin;
    logic              w_inexact;

    assign w_exp_in   = r_a[30:23];
    assign w_frac_in  = r_a[22:0];
    assign w_round_up = r_guard & (r_sticky | r_mant[0]);
    assign w_mant_sum = {1'b0, r_mant} + {24'd0, w_round_up};
    // A carry out of the rounded mantissa renormalizes to 1.0 one binade up.
    assign w_exp_rnd  = r_exp + $signed({9'd0, w_mant_sum[24]});
    assign w_mant_fin = w_mant_sum[24] ? 23'd0 : w_mant_sum[22:0];
    assign w_inexact  = r_guard | r_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_z      <= '0;
            r_status <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a[30:0];
                        r_busy  <= 1'b1;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_mcand  <= {24'd0, 1'b1, w_frac_in};
                    r_mplier <= {1'b1, w_frac_in};
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_exp    <= {1'b0, w_exp_in, 1'b0} - 10'd127;
                    if (w_exp_in == 8'd0) begin
                        // Denormal inputs square far below the normal range.
                        r_z      <= '0;
                        r_status <= (w_frac_in == 23'd0) ? 8'h01 : 8'h29;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_exp_in == 8'hFF) begin
                        r_z      <= (w_frac_in == 23'd0) ? c_INF : c_QNAN;
                        r_status <= (w_frac_in == 23'd0) ? 8'h02 :
                                    (w_frac_in[22] ? 8'h00 : 8'h04);
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd23) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_acc[47]) begin
                        r_mant   <= r_acc[47:24];
                        r_guard  <= r_acc[23];
                        r_sticky <= |r_acc[22:0];
                        r_exp    <= r_exp + 10'sd1;
                    end else begin
                        r_mant   <= r_acc[46:23];
                        r_guard  <= r_acc[22];
                        r_sticky <= |r_acc[21:0];
                    end
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (w_exp_rnd >= 10'sd255) begin
                        r_z      <= c_INF;
                        r_status <= 8'h32;
                    end else if (w_exp_rnd <= 10'sd0) begin
                        r_z      <= '0;
                        r_status <= 8'h29;
                    end else begin
                        r_z      <= {1'b0, w_exp_rnd[7:0], w_mant_fin};
                        r_status <= {2'b00, w_inexact, 5'b00000};
                    end
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.z      = r_z;
    assign bus.status = r_status;
endmodule
`default_nettype wire

// File: tb/tb_fpu_square_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_square_seq
// Brief   : Directed-vector bench for fpu_square_seq with a cycle-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fpu_square_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fpu_square_seq_if bus ();

    fpu_square_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference squaring from the value-level rules: exact product, then RNE by remainder.
    function automatic void ref_sq(input logic [31:0] x, output logic [31:0] rz,
                                   output logic [7:0] rs, output int lat);
        int     e;
        int     sh;
        longint m, p, q, r, half;
        logic [63:0] qv;
        lat = 28;
        if (x[30:23] == 8'd0) begin
            lat = 2; rz = 32'h0;
            rs  = (x[22:0] == 23'd0) ? 8'h01 : 8'h29;
        end else if (x[30:23] == 8'hFF) begin
            lat = 2;
            rz  = (x[22:0] == 23'd0) ? 32'h7F800000 : 32'h7FC00000;
            rs  = (x[22:0] == 23'd0) ? 8'h02 : (x[22] ? 8'h00 : 8'h04);
        end else begin
            m = longint'({1'b1, x[22:0]});
            p = m * m;
            e = 2 * int'(x[30:23]) - 127;
            if (p >= (longint'(1) << 47)) begin sh = 24; e++; end
            else sh = 23;
            q    = p >> sh;
            r    = p - (q << sh);
            half = longint'(1) << (sh - 1);
            qv   = q;
            if (r > half || (r == half && qv[0])) q++;
            if (q == (longint'(1) << 24)) begin q = q >> 1; e++; end
            qv = q;
            if (e >= 255) begin rz = 32'h7F800000; rs = 8'h32; end
            else if (e <= 0) begin rz = 32'h0; rs = 8'h29; end
            else begin
                rz = {1'b0, 8'(e), qv[22:0]};
                rs = (r != 0) ? 8'h20 : 8'h00;
            end
        end
    endfunction

    // Cycle-level expectation: a job occupies the unit for its latency, then one idle cycle.
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_z = '0, p_z = '0;
    logic [7:0]  m_st = '0, p_st = '0;
    int          m_left = 0, m_dones = 0, p_lat = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_z = '0; m_st = '0; m_left = 0;
        end else if (!m_busy) begin
            if (bus.start) begin
                ref_sq(bus.a, p_z, p_st, p_lat);
                m_busy = 1'b1;
                m_left = p_lat - 1;
            end
        end else if (m_done) begin
            m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1; m_z = p_z; m_st = p_st; m_dones++;
            end
        end
    end

    int dut_dones = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check32("busy",   {31'd0, bus.busy}, {31'd0, m_busy});
            check32("done",   {31'd0, bus.done}, {31'd0, m_done});
            check32("z",      bus.z, m_z);
            check32("status", {24'd0, bus.status}, {24'd0, m_st});
            if (bus.done === 1'b1) dut_dones++;
        end
    end

    task automatic run_op(input logic [31:0] x, input logic [31:0] ez,
                          input logic [7:0] es, input int el);
        logic [31:0] mz;
        logic [7:0]  ms;
        int          ml, lat;
        bit          seen;
        ref_sq(x, mz, ms, ml);
        check32("model_z", mz, ez);
        check32("model_status", {24'd0, ms}, {24'd0, es});
        check32("model_latency", ml, el);
        @(posedge clk); #1; bus.start = 1'b1; bus.a = x;
        @(posedge clk); #1; bus.start = 1'b0; bus.a = $urandom;
        seen = 1'b0; lat = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin seen = 1'b1; lat = c; end
        end
        check32("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check32("latency", lat, el);
            check32("dut_z", bus.z, ez);
            check32("dut_status", {24'd0, bus.status}, {24'd0, es});
        end
    endtask

    logic [31:0] vec_a  [12] = '{32'h40400000, 32'hC0400000, 32'h3F800001, 32'h7F000000,
                                 32'h1F800000, 32'h80000000, 32'hFF800000, 32'h7F800001,
                                 32'h7FC00000, 32'h00000001, 32'h3FFFFFFF, 32'h40000000};
    logic [31:0] vec_z  [12] = '{32'h41100000, 32'h41100000, 32'h3F800002, 32'h7F800000,
                                 32'h00000000, 32'h00000000, 32'h7F800000, 32'h7FC00000,
                                 32'h7FC00000, 32'h00000000, 32'h407FFFFE, 32'h40800000};
    logic [7:0]  vec_s  [12] = '{8'h00, 8'h00, 8'h20, 8'h32, 8'h29, 8'h01,
                                 8'h02, 8'h04, 8'h00, 8'h29, 8'h20, 8'h00};
    int          vec_l  [12] = '{28, 28, 28, 28, 28, 2, 2, 2, 2, 2, 28, 28};

    initial begin
        int n;
        bus.start = 1'b0;
        bus.a     = '0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check32("reset_busy",   {31'd0, bus.busy}, 32'd0);
        check32("reset_done",   {31'd0, bus.done}, 32'd0);
        check32("reset_z",      bus.z, 32'd0);
        check32("reset_status", {24'd0, bus.status}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        for (int i = 0; i < 12; i++) run_op(vec_a[i], vec_z[i], vec_s[i], vec_l[i]);

        // Abort mid-multiply: outputs clear and the job never completes.
        @(posedge clk); #1; bus.start = 1'b1; bus.a = 32'h40400000;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check32("abort_busy",   {31'd0, bus.busy}, 32'd0);
        check32("abort_z",      bus.z, 32'd0);
        check32("abort_status", {24'd0, bus.status}, 32'd0);
        n = dut_dones;
        repeat (40) @(negedge clk);
        check32("abort_no_done", dut_dones - n, 32'd0);
        run_op(32'h40000000, 32'h40800000, 8'h00, 28);

        // Reset and start on the same edge: start must be dropped.
        @(posedge clk); #1; rst = 1'b1; bus.start = 1'b1; bus.a = 32'h40400000;
        @(posedge clk); #1; rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check32("rst_start_busy", {31'd0, bus.busy}, 32'd0);

        // start held high while the operand changes every cycle.
        n = dut_dones;
        @(posedge clk); #1; bus.start = 1'b1;
        for (int i = 0; i < 75; i++) begin
            bus.a = (i % 9 == 4) ? 32'h7F800000 : 32'h3F800000 + 32'(i) * 32'h0001D3A7;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        for (int c = 0; c < 40 && bus.busy !== 1'b0; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check32("held_start_dones", dut_dones, m_dones);
        check32("held_start_idle", {31'd0, bus.busy}, 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
